// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-boundary selector registers.
// Provides the select-width helper and common reset/NOP constants.
package pipe_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  // Width needed to index n inputs, never less than one bit.
  function automatic int sel_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N:1 selector with select range check.
// in_range is low when sel does not name an existing input; out is then zero.
module mux_nto1
  import pipe_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = 2,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out,
  output logic                    in_range
);

  // Compare sel against every legal index so an out-of-range value never slices past in_data.
  always_comb begin
    out      = '0;
    in_range = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        out      = in_data[k*WIDTH +: WIDTH];
        in_range = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_sel_reg_mux.sv
// Registered N:1 selector for pipeline boundaries (PC source, operand forwarding).
// Per-edge priority: reset > flush > stall > load. One cycle latency, no
// combinational input-to-output path.
// Optional: define PIPE_SEL_ERR_CNT_EN to add a saturating 16-bit count of sel_err pulses.
module pipe_sel_reg_mux
  import pipe_pkg::*;
#(
  parameter int          WIDTH     = WORD_W,
  parameter int          NUM_IN    = 2,
  parameter logic [31:0] RESET_VAL = PC_RESET_VAL,
  localparam int         SEL_W     = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err
`ifdef PIPE_SEL_ERR_CNT_EN
  ,
  output logic [15:0]             err_cnt
`endif
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] mux_out;
  logic             mux_in_range;

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic             err_d, err_q;

  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data  (in_data),
    .sel      (sel),
    .out      (mux_out),
    .in_range (mux_in_range)
  );

  // Next-state for flush/stall/load; reset is applied in the register block.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    if (flush) begin
      data_d  = RST_V;
      valid_d = 1'b0;
      sel_d   = '0;
    end else if (stall) begin
      // Hold data/valid/sel; in_valid is ignored so no error can be flagged.
    end else if (in_valid) begin
      sel_d = sel;
      if (mux_in_range) begin
        data_d  = mux_out;
        valid_d = 1'b1;
      end else begin
        data_d  = RST_V;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end else begin
      // Idle cycle: drop valid but keep data/sel to avoid needless toggling.
      valid_d = 1'b0;
    end
  end

  // Output registers with synchronous reset to the startup values.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RST_V;
      valid_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
  assign sel_err   = err_q;

`ifdef PIPE_SEL_ERR_CNT_EN
  logic [15:0] cnt_q;

  // Saturating error count; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (err_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_sel_reg_mux.sv
// Bench for pipe_sel_reg_mux: two instances (NUM_IN=4 reset 0, NUM_IN=3 reset 0x0040_0000)
// driven with shared controls. Directed vector table, then randomized run against a model.
module tb_pipe_sel_reg_mux;

  localparam logic [31:0] RB = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset, flush, stall, in_valid;
  logic [1:0]  sel;
  logic [31:0] w [4];
  logic [127:0] in_a;
  logic [95:0]  in_b;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_err, b_err;
  logic [1:0]  a_sel, b_sel;
`ifdef PIPE_SEL_ERR_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  assign in_a = {w[3], w[2], w[1], w[0]};
  assign in_b = {w[2], w[1], w[0]};

  always #5 clk = ~clk;

  pipe_sel_reg_mux #(.WIDTH(32), .NUM_IN(4), .RESET_VAL(32'h0000_0000)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_a), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(a_data), .out_valid(a_valid),
    .out_sel(a_sel), .sel_err(a_err)
`ifdef PIPE_SEL_ERR_CNT_EN
    , .err_cnt(a_cnt)
`endif
  );

  pipe_sel_reg_mux #(.WIDTH(32), .NUM_IN(3), .RESET_VAL(RB)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_b), .sel(sel), .in_valid(in_valid),
    .stall(stall), .flush(flush), .out_data(b_data), .out_valid(b_valid),
    .out_sel(b_sel), .sel_err(b_err)
`ifdef PIPE_SEL_ERR_CNT_EN
    , .err_cnt(b_cnt)
`endif
  );

  typedef struct {
    logic rst, fl, st, iv;
    logic [1:0] s;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] ad; logic av; logic [1:0] as; logic ae;
    logic [31:0] bd; logic bv; logic [1:0] bs; logic be;
  } vec_t;

  vec_t vq[$];
  int n_chk = 0;
  int n_pass = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [31:0] m_data [2];
  logic        m_valid[2];
  logic [1:0]  m_sel  [2];
  logic        m_err  [2];
  int          m_cnt  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic addv(input logic rst, fl, st, iv, input logic [1:0] s,
                      input logic [31:0] w0, w1, w2, w3,
                      input logic [31:0] ad, input logic av, input logic [1:0] as, input logic ae,
                      input logic [31:0] bd, input logic bv, input logic [1:0] bs, input logic be);
    vec_t v;
    v.rst = rst; v.fl = fl; v.st = st; v.iv = iv; v.s = s;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.w3 = w3;
    v.ad = ad; v.av = av; v.as = as; v.ae = ae;
    v.bd = bd; v.bv = bv; v.bs = bs; v.be = be;
    vq.push_back(v);
  endtask

  // Apply the current inputs to the model: one clock edge of the specified behaviour.
  task automatic model_step();
    int num;
    logic [31:0] rv;
    for (int d = 0; d < 2; d++) begin
      num = (d == 0) ? 4 : 3;
      rv  = (d == 0) ? 32'h0 : RB;
      if (reset) begin
        m_data[d] = rv; m_valid[d] = 1'b0; m_sel[d] = 2'd0; m_err[d] = 1'b0; m_cnt[d] = 0;
      end else if (flush) begin
        m_data[d] = rv; m_valid[d] = 1'b0; m_sel[d] = 2'd0; m_err[d] = 1'b0;
      end else if (stall) begin
        m_err[d] = 1'b0;
      end else if (in_valid) begin
        m_sel[d] = sel;
        if (int'(sel) < num) begin
          m_data[d] = w[sel]; m_valid[d] = 1'b1; m_err[d] = 1'b0;
        end else begin
          m_data[d] = rv; m_valid[d] = 1'b0; m_err[d] = 1'b1;
          if (m_cnt[d] < 65535) m_cnt[d]++;
        end
      end else begin
        m_valid[d] = 1'b0; m_err[d] = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; sel = 2'd0;
    for (int k = 0; k < 4; k++) w[k] = 32'h0;

    //     rst fl st iv sel  w0            w1            w2            w3             a: data valid sel err            b: data valid sel err
    addv(1, 0, 0, 1, 2'd1, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,         32'h0,        0, 2'd0, 0,  RB,           0, 2'd0, 0);
    addv(1, 0, 0, 1, 2'd1, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,         32'h0,        0, 2'd0, 0,  RB,           0, 2'd0, 0);
    addv(0, 0, 0, 1, 2'd1, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,         32'hDEADBEEF, 1, 2'd1, 0,  32'hDEADBEEF, 1, 2'd1, 0);
    addv(0, 0, 0, 1, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,  32'h11111111, 1, 2'd0, 0,  32'h11111111, 1, 2'd0, 0);
    addv(0, 0, 0, 1, 2'd1, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,  32'h22222222, 1, 2'd1, 0,  32'h22222222, 1, 2'd1, 0);
    addv(0, 0, 0, 1, 2'd2, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,  32'h33333333, 1, 2'd2, 0,  32'h33333333, 1, 2'd2, 0);
    addv(0, 0, 0, 1, 2'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,  32'h44444444, 1, 2'd3, 0,  RB,           0, 2'd3, 1);
    addv(0, 0, 0, 0, 2'd0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,  32'h44444444, 0, 2'd3, 0,  RB,           0, 2'd3, 0);
    addv(0, 0, 0, 1, 2'd0, 32'hAAAA0001, 32'h0,        32'h0,        32'h0,         32'hAAAA0001, 1, 2'd0, 0,  32'hAAAA0001, 1, 2'd0, 0);
    addv(0, 0, 1, 1, 2'd0, 32'hBBBB0002, 32'h0,        32'h0,        32'h0,         32'hAAAA0001, 1, 2'd0, 0,  32'hAAAA0001, 1, 2'd0, 0);
    addv(0, 0, 1, 1, 2'd0, 32'hBBBB0002, 32'h0,        32'h0,        32'h0,         32'hAAAA0001, 1, 2'd0, 0,  32'hAAAA0001, 1, 2'd0, 0);
    addv(0, 0, 1, 1, 2'd0, 32'hBBBB0002, 32'h0,        32'h0,        32'h0,         32'hAAAA0001, 1, 2'd0, 0,  32'hAAAA0001, 1, 2'd0, 0);
    addv(0, 0, 0, 1, 2'd0, 32'hBBBB0002, 32'h0,        32'h0,        32'h0,         32'hBBBB0002, 1, 2'd0, 0,  32'hBBBB0002, 1, 2'd0, 0);
    addv(0, 1, 1, 1, 2'd1, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'h0,        0, 2'd0, 0,  RB,           0, 2'd0, 0);
    addv(0, 0, 1, 1, 2'd3, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'h0,        0, 2'd0, 0,  RB,           0, 2'd0, 0);
    addv(0, 0, 0, 1, 2'd3, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'hCAFE0003, 1, 2'd3, 0,  RB,           0, 2'd3, 1);
    addv(0, 0, 0, 1, 2'd1, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'h12345678, 1, 2'd1, 0,  32'h12345678, 1, 2'd1, 0);
    addv(0, 0, 0, 1, 2'd3, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'hCAFE0003, 1, 2'd3, 0,  RB,           0, 2'd3, 1);
    addv(1, 0, 0, 1, 2'd1, 32'h0,        32'h12345678, 32'h0,        32'hCAFE0003,  32'h0,        0, 2'd0, 0,  RB,           0, 2'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; flush = vq[i].fl; stall = vq[i].st; in_valid = vq[i].iv; sel = vq[i].s;
      w[0] = vq[i].w0; w[1] = vq[i].w1; w[2] = vq[i].w2; w[3] = vq[i].w3;
      @(posedge clk); #1;
      check($sformatf("v%0d a_data", i),  a_data,         vq[i].ad);
      check($sformatf("v%0d a_valid", i), 32'(a_valid),   32'(vq[i].av));
      check($sformatf("v%0d a_sel", i),   32'(a_sel),     32'(vq[i].as));
      check($sformatf("v%0d a_err", i),   32'(a_err),     32'(vq[i].ae));
      check($sformatf("v%0d b_data", i),  b_data,         vq[i].bd);
      check($sformatf("v%0d b_valid", i), 32'(b_valid),   32'(vq[i].bv));
      check($sformatf("v%0d b_sel", i),   32'(b_sel),     32'(vq[i].bs));
      check($sformatf("v%0d b_err", i),   32'(b_err),     32'(vq[i].be));
    end

    // Last table row was a reset, so the model starts from reset state.
    m_data[0] = 32'h0; m_data[1] = RB;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_sel[d] = 2'd0; m_err[d] = 1'b0; m_cnt[d] = 0;
    end

    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 39) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      stall    = ($urandom_range(0, 4) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      sel      = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      model_step();
      @(posedge clk); #1;
      check($sformatf("r%0d a_data", i),  a_data,       m_data[0]);
      check($sformatf("r%0d a_valid", i), 32'(a_valid), 32'(m_valid[0]));
      check($sformatf("r%0d a_sel", i),   32'(a_sel),   32'(m_sel[0]));
      check($sformatf("r%0d a_err", i),   32'(a_err),   32'(m_err[0]));
      check($sformatf("r%0d b_data", i),  b_data,       m_data[1]);
      check($sformatf("r%0d b_valid", i), 32'(b_valid), 32'(m_valid[1]));
      check($sformatf("r%0d b_sel", i),   32'(b_sel),   32'(m_sel[1]));
      check($sformatf("r%0d b_err", i),   32'(b_err),   32'(m_err[1]));
`ifdef PIPE_SEL_ERR_CNT_EN
      check($sformatf("r%0d a_cnt", i),   32'(a_cnt),   32'(m_cnt[0]));
      check($sformatf("r%0d b_cnt", i),   32'(b_cnt),   32'(m_cnt[1]));
`endif
    end

`ifdef PIPE_SEL_ERR_CNT_EN
    // Saturation: 2^16+5 bad selects on the 3-input instance.
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b1; sel = 2'd3;
    @(posedge clk); #1;
    check("cnt after reset", 32'(b_cnt), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 65541; i++) @(posedge clk);
    #1;
    check("cnt saturated", 32'(b_cnt), 32'hFFFF);
    check("cnt a zero", 32'(a_cnt), 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    check("cnt after flush", 32'(b_cnt), 32'hFFFF);
    flush = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    check("cnt cleared", 32'(b_cnt), 32'h0);
    reset = 1'b0; in_valid = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_sel_reg_mux.md
Name: pipe_sel_reg_mux

Overview:
Parametrised N-input, WIDTH-bit selector followed by a registered output stage. It is used at pipeline boundaries such as PC-source selection and EX operand forwarding. It replaces fixed 32-bit 2:1 muxes feeding pipeline registers and supports stall (hold), flush (bubble) and defined startup. Startup is handled by a real synchronous reset, not by a default case arm.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 2, number of data inputs; legal range 2..16
RESET_VAL, 32'h0000_0000, value loaded into out_data on reset and flush (PC startup = 0)
SEL_W, $clog2(NUM_IN), select width; derived localparam, not overridable

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  in  SEL_W  input index
in_valid  in  1  qualifies in_data/sel this cycle
stall  in  1  hold all outputs
flush  in  1  insert bubble
out_data  out  WIDTH  registered selected data
out_valid  out  1  registered valid
out_sel  out  SEL_W  registered copy of the index that produced out_data
sel_err  out  1  one-cycle pulse: in_valid with sel >= NUM_IN was captured

Behaviour:
- Decided: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_data=RESET_VAL, out_valid=0, out_sel=0, sel_err=0.
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N. There is no combinational path from any input to any output.
- Per-edge priority: reset > flush > stall > load.
- flush: out_data=RESET_VAL, out_valid=0, out_sel=0, sel_err=0. Flush wins over a simultaneous stall.
- stall (no flush): out_data, out_valid and out_sel hold their values. sel_err=0. in_valid is ignored, so no error is flagged while stalled.
- load, in_valid=1, sel<NUM_IN: out_data=in_data[sel], out_valid=1, out_sel=sel, sel_err=0.
- load, in_valid=1, sel>=NUM_IN (possible only when NUM_IN is not a power of 2): out_data=RESET_VAL, out_valid=0, out_sel=sel, sel_err=1 for one cycle.
- load, in_valid=0: out_valid=0, sel_err=0. out_data and out_sel hold their values, which avoids toggling.
- sel_err is a pulse, not a sticky flag. It is cleared on the next non-error edge.
- Reset asserted mid-stream: the outputs take their reset values on that edge. The first load after reset deasserts is accepted on the following edge.
- Widths: RESET_VAL is truncated or zero-extended to WIDTH. SEL_W is a minimum of 1.

Optional Feature:
Macro PIPE_SEL_ERR_CNT_EN.
- Defined: adds output err_cnt [15:0], a saturating count of sel_err pulses. It resets to 0 on reset, does not clear on flush, and holds at 16'hFFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - a clog2-based SEL_W helper function with a minimum of 1
  - PC_RESET_VAL = 32'h0000_0000
  - NOP_INSTR = 32'h0000_0000
  - default WORD_W = 32
- One combinational sub-module, mux_nto1 (params WIDTH, NUM_IN; ports in_data, sel, out, in_range). It does the indexed select and the range check. pipe_sel_reg_mux instantiates it and owns all registers.

Test Plan:
- Reset: WIDTH=32, NUM_IN=2, RESET_VAL=0; hold reset 2 cycles with in_valid=1, sel=1, in1=32'hDEAD_BEEF -> out_data=0, out_valid=0 throughout; DEAD_BEEF appears 1 cycle after reset drops.
- Select sweep: NUM_IN=4, inputs 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; sel=0,1,2,3 on consecutive cycles -> out_data follows one cycle later, out_sel matches, out_valid=1.
- Stall: load 32'hAAAA_0001, then stall 3 cycles while inputs change to 32'hBBBB_0002 -> out_data stays AAAA_0001 and out_valid stays 1; BBBB_0002 appears 1 cycle after stall drops.
- Flush vs stall: RESET_VAL=32'h0040_0000; flush=1 and stall=1 on the same cycle -> out_data=32'h0040_0000, out_valid=0.
- Bad select: NUM_IN=3, in_valid=1, sel=3 -> sel_err=1 for exactly 1 cycle, out_valid=0, out_data=RESET_VAL, out_sel=3. With stall=1 on the same cycle -> sel_err=0.
- With PIPE_SEL_ERR_CNT_EN defined: force 2^16+5 bad selects -> err_cnt saturates at 16'hFFFF; a flush leaves it unchanged; reset clears it to 0.
